// File: rtl/rgb_pixel_streamer.sv
// rgb_pixel_streamer: reads a packed RGB frame from SRAM in raster order and
// unpacks the three-word/two-pixel layout onto a valid/ready pixel stream.
// Ports:
//   CLOCK_50_I, reset        clock, synchronous active-high reset
//   start                    one-cycle frame request (ignored while busy)
//   SRAM_read_data/address   SRAM read port (2-cycle read latency)
//   SRAM_we_n                tied high, this block only reads
//   pix_valid/pix_ready      pixel stream handshake
//   pix_r/g/b, eol, last     pixel payload and row/frame markers
//   busy, done               frame in progress, end-of-frame pulse
module rgb_pixel_streamer #(
    parameter logic [17:0] RGB_BASE = 18'd146944,
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 240
) (
    input  logic        CLOCK_50_I,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_eol,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NPIX   = WIDTH * HEIGHT;
    localparam int unsigned NWORDS = NPIX * 3 / 2;
    localparam int unsigned CNT_W  = $clog2(NWORDS + 1);
    localparam int unsigned COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic [17:0]        r_addr;
    logic [CNT_W-1:0]   r_issued;
    logic               r_v0, r_v1, r_v2;   // read issued 0/1/2 cycles ago
    logic [15:0]        r_mem [4];
    logic [1:0]         r_wp, r_rp;
    logic [2:0]         r_cnt;
    logic [1:0]         r_phase;
    logic [7:0]         r_hold_r, r_hold_g;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_valid, r_eol, r_last;
    logic [7:0]         r_pr, r_pg, r_pb;
    logic               r_busy, r_done;

    logic               w_active, w_hs, w_out_free, w_pop, w_load, w_push, w_issue;
    logic               w_col_eol, w_col_last;
    logic [3:0]         w_total;
    logic [15:0]        w_word;

    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_hs       = r_valid && pix_ready;
    assign w_out_free = !r_valid || pix_ready;
    assign w_word     = r_mem[r_rp];
    assign w_pop      = w_active && (r_cnt != 3'd0) && ((r_phase == 2'd0) || w_out_free);
    assign w_load     = w_pop && (r_phase != 2'd0);
    assign w_push     = w_active && r_v2;
    // Buffered plus in-flight words as they will stand next cycle, before a new read.
    assign w_total    = 4'(r_cnt) + 4'(r_v0) + 4'(r_v1) + 4'(r_v2) - 4'(w_pop);
    assign w_issue    = (r_state == S_RUN) && (r_issued != CNT_W'(NWORDS)) && (w_total < 4'd4);
    assign w_col_eol  = (r_col == COL_W'(WIDTH - 1));
    assign w_col_last = w_col_eol && (r_row == ROW_W'(HEIGHT - 1));

    // State register
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN: begin
                if (w_hs && r_last)                      w_state_next = S_DONE;
                else if (r_issued == CNT_W'(NWORDS))     w_state_next = S_DRAIN;
            end
            S_DRAIN: if (w_hs && r_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Word FIFO storage (contents need no reset; occupancy is tracked separately)
    always_ff @(posedge CLOCK_50_I) begin
        if (w_push) r_mem[r_wp] <= SRAM_read_data;
    end

    // Read issue, FIFO pointers, unpacker and output register
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_addr   <= '0;
            r_issued <= '0;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_hold_r <= '0;
            r_hold_g <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_valid  <= 1'b0;
            r_eol    <= 1'b0;
            r_last   <= 1'b0;
            r_pr     <= '0;
            r_pg     <= '0;
            r_pb     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
            r_v1   <= r_v0;
            r_v2   <= r_v1;
            r_v0   <= 1'b0;
            if ((r_state == S_IDLE) && start) begin
                // First read goes out the cycle after start.
                r_addr   <= RGB_BASE;
                r_v0     <= 1'b1;
                r_issued <= CNT_W'(1);
                r_wp     <= '0;
                r_rp     <= '0;
                r_cnt    <= '0;
                r_phase  <= '0;
                r_col    <= '0;
                r_row    <= '0;
                r_valid  <= 1'b0;
                r_eol    <= 1'b0;
                r_last   <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + 18'd1;
                    r_v0     <= 1'b1;
                    r_issued <= r_issued + CNT_W'(1);
                end
                if (w_push) r_wp <= r_wp + 2'd1;
                if (w_pop)  r_rp <= r_rp + 2'd1;
                r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);

                if (w_pop) begin
                    r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
                    case (r_phase)
                        2'd0: begin
                            r_hold_r <= w_word[15:8];
                            r_hold_g <= w_word[7:0];
                        end
                        2'd1: begin
                            r_pr     <= r_hold_r;
                            r_pg     <= r_hold_g;
                            r_pb     <= w_word[15:8];
                            r_hold_r <= w_word[7:0];
                        end
                        default: begin
                            r_pr <= r_hold_r;
                            r_pg <= w_word[15:8];
                            r_pb <= w_word[7:0];
                        end
                    endcase
                end

                // A load only happens when the register is free, so stalled data holds.
                if (w_load) begin
                    r_valid <= 1'b1;
                    r_eol   <= w_col_eol;
                    r_last  <= w_col_last;
                    r_col   <= w_col_eol ? '0 : r_col + COL_W'(1);
                    if (w_col_eol) r_row <= r_row + ROW_W'(1);
                end else if (w_hs) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign SRAM_address = r_addr;
    assign SRAM_we_n    = 1'b1;
    assign pix_valid    = r_valid;
    assign pix_r        = r_pr;
    assign pix_g        = r_pg;
    assign pix_b        = r_pb;
    assign pix_eol      = r_eol;
    assign pix_last     = r_last;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
